bus_write_sequencer: RTL and testbench

- Upstream master for `bus_decoder`. Accepts write requests (addr, data) over a valid/ready interface and queues them in a small FIFO.
- Drives the decoder's EN/addr/DIN inputs, meeting its protocol: EN rising edge → one-cycle select pulse, then EN must return low before the next write.
- Issues one decoder write per 3 clocks at full throughput, and reports completion and bad addresses.

---
 rtl/bus_write_sequencer_pkg.sv | 14 +
 rtl/bus_write_sequencer_sync_fifo.sv | 51 +++++
 rtl/bus_write_sequencer.sv | 109 ++++++++++
 tb/tb_bus_write_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_write_sequencer_pkg.sv
// Shared types and constants for the bus write sequencer.
package bus_write_sequencer_pkg;

  typedef enum logic [2:0] {
    SETTLE,
    IDLE,
    DRIVE,
    HOLD,
    RELEASE
  } seq_state_t;

  localparam int unsigned SETTLE_CYCLES = 2;

endpackage

// File: rtl/bus_write_sequencer_sync_fifo.sv
// Small synchronous FIFO with a combinational head output and an occupancy count.
module bus_write_sequencer_sync_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/bus_write_sequencer.sv
// Queues write requests and replays them into bus_decoder with an EN 1,1,0 cadence.
module bus_write_sequencer
  import bus_write_sequencer_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned B        = $clog2(N),
  parameter int unsigned WORDSIZE = 16,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [B-1:0]            wr_addr,
  input  logic [WORDSIZE-1:0]     wr_data,
  output logic                    bus_en,
  output logic [B-1:0]            bus_addr,
  output logic [WORDSIZE-1:0]     bus_data,
  output logic                    wr_done,
  output logic                    addr_err,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned FW  = B + WORDSIZE;
  localparam int unsigned AW1 = B + 1;
  localparam int unsigned SW  = $clog2(SETTLE_CYCLES + 1);

  seq_state_t          state_q, state_d;
  logic [SW-1:0]       settle_q;
  logic [FW-1:0]       head;
  logic [B-1:0]        head_addr;
  logic [WORDSIZE-1:0] head_data;
  logic                head_ok;
  logic                fifo_full, fifo_empty;
  logic                push, pop;
  logic                bus_en_d, wr_done_d, addr_err_d;

  assign head_addr = head[WORDSIZE +: B];
  assign head_data = head[WORDSIZE-1:0];
  assign head_ok   = ({1'b0, head_addr} < AW1'(N));
  assign wr_ready  = !fifo_full && (state_q != SETTLE);
  assign push      = wr_valid && wr_ready;
  assign busy      = !fifo_empty || (state_q != IDLE);

  bus_write_sequencer_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({wr_addr, wr_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Next state; RELEASE may pop straight into DRIVE to keep one write per 3 clocks.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    addr_err_d = 1'b0;
    case (state_q)
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = IDLE;
      end
      IDLE, RELEASE: begin
        state_d = IDLE;
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_ok) state_d = DRIVE;
          else         addr_err_d = 1'b1;
        end
      end
      DRIVE:   state_d = HOLD;
      HOLD:    state_d = RELEASE;
      default: state_d = SETTLE;
    endcase
    bus_en_d  = (state_d == DRIVE) || (state_d == HOLD);
    wr_done_d = (state_d == RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SETTLE;
      settle_q <= '0;
      bus_en   <= 1'b0;
      bus_addr <= '0;
      bus_data <= '0;
      wr_done  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= (state_q == SETTLE) ? settle_q + SW'(1) : '0;
      bus_en   <= bus_en_d;
      wr_done  <= wr_done_d;
      addr_err <= addr_err_d;
      // Address/data only move on a pop so they stay stable through HOLD.
      if (pop) begin
        bus_addr <= head_addr;
        bus_data <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_bus_write_sequencer.sv
// Bench for bus_write_sequencer: decoder model, request scoreboard and scenario tasks.
module tb_bus_write_sequencer;

  localparam int unsigned N     = 6;
  localparam int unsigned B     = 3;
  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [B-1:0]  wr_addr;
  logic [W-1:0]  wr_data;
  logic          bus_en;
  logic [B-1:0]  bus_addr;
  logic [W-1:0]  bus_data;
  logic          wr_done;
  logic          addr_err;
  logic          busy;
  logic [LW-1:0] level;

  int tests = 0;
  int fails = 0;

  bus_write_sequencer #(.N(N), .B(B), .WORDSIZE(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .bus_en(bus_en), .bus_addr(bus_addr),
    .bus_data(bus_data), .wr_done(wr_done), .addr_err(addr_err), .busy(busy),
    .level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decoder model: OFF -> NOP on rising EN, NOP selects for one cycle then ON, ON -> OFF on EN low.
  typedef enum logic [1:0] {D_OFF, D_NOP, D_ON} dec_t;
  dec_t dec = D_ON;
  logic [7:0] reg_sel;
  assign reg_sel = (dec == D_NOP) ? (8'd1 << bus_addr) : 8'd0;

  always @(posedge clk) begin
    case (dec)
      D_OFF:   if (bus_en === 1'b1) dec <= D_NOP;
      D_NOP:   dec <= D_ON;
      default: if (bus_en !== 1'b1) dec <= D_OFF;
    endcase
  end

  typedef struct packed {
    logic [7:0]   sel;
    logic [W-1:0] data;
  } pulse_t;

  pulse_t       exp_q[$];
  pulse_t       obs_q[$];
  pulse_t       acc_p, mon_p;
  int           acc_cnt = 0, exp_err = 0;
  int           iss_cnt = 0, err_cnt = 0, done_cnt = 0;
  logic         prev_en = 1'b0;
  logic [B-1:0] last_addr = '0;
  logic [W-1:0] last_data = '0;

  // Scoreboard of accepted requests; reset discards everything queued.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_cnt <= 0;
      exp_err <= 0;
    end else if (wr_valid && wr_ready) begin
      acc_cnt   <= acc_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
      if (int'(wr_addr) < N) begin
        acc_p.sel  = 8'd1 << wr_addr;
        acc_p.data = wr_data;
        exp_q.push_back(acc_p);
      end else begin
        exp_err <= exp_err + 1;
      end
    end
  end

  // Observed decoder selects and issued requests (EN rise or addr_err each retire one entry).
  always @(negedge clk) begin
    if (!rst_n) begin
      obs_q.delete();
      iss_cnt  <= 0;
      err_cnt  <= 0;
      done_cnt <= 0;
      prev_en  <= 1'b0;
    end else begin
      iss_cnt  <= iss_cnt + int'(bus_en && !prev_en) + int'(addr_err);
      err_cnt  <= err_cnt + int'(addr_err);
      done_cnt <= done_cnt + int'(wr_done);
      prev_en  <= bus_en;
      if (reg_sel != 8'd0) begin
        mon_p.sel  = reg_sel;
        mon_p.data = bus_data;
        obs_q.push_back(mon_p);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    tests++; if (bus_en !== 1'b0)   begin fails++; $display("FAIL reset_bus_en got %b want 0", bus_en); end
    tests++; if (bus_addr !== '0)   begin fails++; $display("FAIL reset_bus_addr got %0d want 0", bus_addr); end
    tests++; if (bus_data !== '0)   begin fails++; $display("FAIL reset_bus_data got %h want 0", bus_data); end
    tests++; if (wr_done !== 1'b0)  begin fails++; $display("FAIL reset_wr_done got %b want 0", wr_done); end
    tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL reset_addr_err got %b want 0", addr_err); end
    tests++; if (level !== '0)      begin fails++; $display("FAIL reset_level got %0d want 0", level); end
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
    tests++; if (busy !== 1'b1)     begin fails++; $display("FAIL reset_busy got %b want 1", busy); end
    rst_n = 1'b1;
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL settle0_ready got %b want 0", wr_ready); end
    tick();
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL settle1_ready got %b want 0", wr_ready); end
    tick();
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL settle_done_ready got %b want 1", wr_ready); end
  endtask

  task automatic test_single();
    logic [5:0]   en_v, done_v, hit_v;
    logic [7:0]   sel2;
    logic [W-1:0] dat2;
    sel2 = '0; dat2 = '0;
    wr_valid = 1'b1; wr_addr = B'(3); wr_data = 16'hA5A5;
    tick();
    wr_valid = 1'b0;
    tests++; if (level !== LW'(1)) begin fails++; $display("FAIL single_level got %0d want 1", level); end
    for (int k = 0; k < 6; k++) begin
      en_v[k]   = bus_en;
      done_v[k] = wr_done;
      hit_v[k]  = (reg_sel != 8'd0);
      if (k == 2) begin sel2 = reg_sel; dat2 = bus_data; end
      if (k < 5) tick();
    end
    tests++; if (en_v !== 6'b000110)   begin fails++; $display("FAIL single_en got %b want 000110", en_v); end
    tests++; if (hit_v !== 6'b000100)  begin fails++; $display("FAIL single_sel_cycle got %b want 000100", hit_v); end
    tests++; if (sel2 !== 8'b0000_1000) begin fails++; $display("FAIL single_reg_sel got %b want 00001000", sel2); end
    tests++; if (dat2 !== 16'hA5A5)    begin fails++; $display("FAIL single_din got %h want a5a5", dat2); end
    tests++; if (done_v !== 6'b001000) begin fails++; $display("FAIL single_done got %b want 001000", done_v); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d[6];
    logic         en_log[$];
    logic         rdy;
    int           i = 0;
    int           base = obs_q.size();
    bit           started = 0;
    bit           saw_full = 0;
    for (int k = 0; k < 6; k++) d[k] = W'($urandom);
    for (int c = 0; c < 40; c++) begin
      if (i < 6) begin wr_valid = 1'b1; wr_addr = B'(i); wr_data = d[i]; end
      else wr_valid = 1'b0;
      rdy = wr_ready;
      tick();
      if (wr_valid && rdy) i++;
      tests++; if (int'(level) !== acc_cnt - iss_cnt) begin fails++; $display("FAIL b2b_level got %0d want %0d", level, acc_cnt - iss_cnt); end
      if (int'(level) == DEPTH) begin
        saw_full = 1;
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_full got %b want 0", wr_ready); end
      end
      if (bus_en) started = 1;
      if (started && en_log.size() < 18) en_log.push_back(bus_en);
    end
    wr_valid = 1'b0;
    tests++; if (!saw_full) begin fails++; $display("FAIL b2b_reached_full got 0 want 1"); end
    tests++; if (en_log.size() != 18) begin fails++; $display("FAIL b2b_en_len got %0d want 18", en_log.size()); end
    for (int j = 0; j < en_log.size(); j++) begin
      tests++; if (en_log[j] !== ((j % 3) != 2)) begin fails++; $display("FAIL b2b_en_pattern[%0d] got %b want %b", j, en_log[j], (j % 3) != 2); end
    end
    tests++; if (obs_q.size() - base != 6) begin fails++; $display("FAIL b2b_count got %0d want 6", obs_q.size() - base); end
    for (int k = 0; k < 6 && base + k < obs_q.size(); k++) begin
      tests++;
      if (obs_q[base+k].sel !== (8'd1 << k) || obs_q[base+k].data !== d[k]) begin
        fails++; $display("FAIL b2b_write[%0d] got sel=%b data=%h want sel=%b data=%h", k, obs_q[base+k].sel, obs_q[base+k].data, 8'd1 << k, d[k]);
      end
    end
  endtask

  task automatic test_full();
    int   i = 0;
    int   base = obs_q.size();
    int   ebase = exp_q.size();
    int   prev_level = 0;
    bit   refused = 0, saw_refuse = 0, chk_next = 0, refilled = 0;
    logic rdy;
    for (int c = 0; c < 50; c++) begin
      if (i < 8) begin wr_valid = 1'b1; wr_addr = B'($urandom_range(0, N - 1)); wr_data = W'($urandom); end
      else wr_valid = 1'b0;
      rdy = wr_ready;
      refused = wr_valid && !rdy;
      prev_level = int'(level);
      tick();
      if (wr_valid && rdy) i++;
      tests++; if (int'(level) !== acc_cnt - iss_cnt) begin fails++; $display("FAIL full_level got %0d want %0d", level, acc_cnt - iss_cnt); end
      if (chk_next) begin
        chk_next = 0; refilled = 1;
        tests++; if (int'(level) != DEPTH) begin fails++; $display("FAIL full_refill got %0d want %0d", level, DEPTH); end
      end
      if (prev_level == DEPTH && refused && int'(level) == DEPTH - 1) begin
        saw_refuse = 1;
        chk_next = (i < 8);
      end
    end
    wr_valid = 1'b0;
    tests++; if (!saw_refuse) begin fails++; $display("FAIL full_push_pop_refused got 0 want 1"); end
    tests++; if (!refilled)   begin fails++; $display("FAIL full_refill_seen got 0 want 1"); end
    tests++; if (obs_q.size() - base != 8 || exp_q.size() - ebase != 8) begin
      fails++; $display("FAIL full_count got obs=%0d exp=%0d want 8", obs_q.size() - base, exp_q.size() - ebase);
    end
    for (int k = 0; k < 8 && base + k < obs_q.size() && ebase + k < exp_q.size(); k++) begin
      tests++; if (obs_q[base+k] !== exp_q[ebase+k]) begin fails++; $display("FAIL full_write[%0d] got %h want %h", k, obs_q[base+k], exp_q[ebase+k]); end
    end
  endtask

  task automatic test_addr_err();
    int           base = obs_q.size();
    int           err0 = err_cnt;
    int           done0 = done_cnt;
    int           err_at = -1, en_at = -1, en_n = 0;
    logic [W-1:0] dat = W'($urandom);
    for (int c = 0; c < 15; c++) begin
      wr_valid = (c < 2);
      wr_addr  = (c == 0) ? B'(7) : B'(2);
      wr_data  = dat;
      tick();
      if (addr_err && err_at < 0) err_at = c;
      if (bus_en) begin en_n++; if (en_at < 0) en_at = c; end
    end
    wr_valid = 1'b0;
    tests++; if (err_cnt - err0 != 1)   begin fails++; $display("FAIL err_pulses got %0d want 1", err_cnt - err0); end
    tests++; if (err_at != 1)           begin fails++; $display("FAIL err_cycle got %0d want 1", err_at); end
    tests++; if (en_at != 2 || en_n != 2) begin fails++; $display("FAIL err_en got first=%0d cycles=%0d want first=2 cycles=2", en_at, en_n); end
    tests++; if (done_cnt - done0 != 1) begin fails++; $display("FAIL err_done got %0d want 1", done_cnt - done0); end
    tests++;
    if (obs_q.size() - base != 1) begin
      fails++; $display("FAIL err_writes got %0d want 1", obs_q.size() - base);
    end else if (obs_q[base].sel !== 8'b0000_0100 || obs_q[base].data !== dat) begin
      fails++; $display("FAIL err_write got sel=%b data=%h want sel=00000100 data=%h", obs_q[base].sel, obs_q[base].data, dat);
    end
  endtask

  task automatic test_random();
    int base = obs_q.size();
    int ebase = exp_q.size();
    int err0 = err_cnt, eerr0 = exp_err, done0 = done_cnt;
    int guard = 0;
    for (int c = 0; c < 40; c++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = B'($urandom_range(0, 7));
      wr_data  = W'($urandom);
      tick();
      tests++; if (int'(level) !== acc_cnt - iss_cnt) begin fails++; $display("FAIL rand_level got %0d want %0d", level, acc_cnt - iss_cnt); end
    end
    wr_valid = 1'b0;
    while (busy && guard < 200) begin
      tick();
      guard++;
    end
    repeat (2) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rand_drain got busy=%b want 0", busy); end
    tests++; if (obs_q.size() - base != exp_q.size() - ebase) begin
      fails++; $display("FAIL rand_count got %0d want %0d", obs_q.size() - base, exp_q.size() - ebase);
    end
    for (int k = 0; base + k < obs_q.size() && ebase + k < exp_q.size(); k++) begin
      tests++; if (obs_q[base+k] !== exp_q[ebase+k]) begin fails++; $display("FAIL rand_write[%0d] got %h want %h", k, obs_q[base+k], exp_q[ebase+k]); end
    end
    tests++; if (err_cnt - err0 != exp_err - eerr0) begin fails++; $display("FAIL rand_errs got %0d want %0d", err_cnt - err0, exp_err - eerr0); end
    tests++; if (done_cnt - done0 != exp_q.size() - ebase) begin fails++; $display("FAIL rand_done got %0d want %0d", done_cnt - done0, exp_q.size() - ebase); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] dat = W'($urandom);
    for (int c = 0; c < 3; c++) begin
      wr_valid = 1'b1;
      wr_addr  = (c == 0) ? B'(4) : (c == 1) ? B'(5) : B'(0);
      wr_data  = W'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    tests++; if (bus_en !== 1'b1 || level !== LW'(2)) begin fails++; $display("FAIL mid_hold got en=%b level=%0d want en=1 level=2", bus_en, level); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus_en !== 1'b0) begin fails++; $display("FAIL mid_en_drop got %b want 0", bus_en); end
    tests++; if (level !== '0 || wr_ready !== 1'b0) begin fails++; $display("FAIL mid_flush got level=%0d ready=%b want 0 0", level, wr_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL mid_settle got ready=%b want 0", wr_ready); end
    tick();
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b want 1", wr_ready); end
    wr_valid = 1'b1; wr_addr = B'(1); wr_data = dat;
    tick();
    wr_valid = 1'b0;
    repeat (8) tick();
    tests++;
    if (obs_q.size() != 1) begin
      fails++; $display("FAIL mid_pulses got %0d want 1", obs_q.size());
    end else if (obs_q[0].sel !== 8'b0000_0010 || obs_q[0].data !== dat) begin
      fails++; $display("FAIL mid_write got sel=%b data=%h want sel=00000010 data=%h", obs_q[0].sel, obs_q[0].data, dat);
    end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL mid_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_idle_soak();
    for (int c = 0; c < 50; c++) begin
      tick();
      tests++;
      if (bus_en !== 1'b0 || busy !== 1'b0 || wr_done !== 1'b0 || bus_addr !== last_addr || bus_data !== last_data) begin
        fails++;
        $display("FAIL soak[%0d] got en=%b busy=%b done=%b addr=%0d data=%h want 0 0 0 addr=%0d data=%h",
                 c, bus_en, busy, wr_done, bus_addr, bus_data, last_addr, last_data);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_addr_err();
    test_random();
    test_reset_mid();
    test_idle_soak();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
